// File: rtl/pkt_filter_pkg.sv
// pkt_filter_pkg: shared types, width helpers and saturating counter step for packet_filter_mc
package pkt_filter_pkg;
  localparam int CHAN_MAX_W = 8;
  localparam int LEN_MAX_W = 16;
  typedef struct packed {
    logic [CHAN_MAX_W-1:0] channel;
    logic [LEN_MAX_W-1:0]  len;
  } desc_t;
  typedef enum logic [1:0] {W_IDLE, W_PKT, W_OVR} wr_state_e;
  typedef enum logic {R_IDLE, R_XFER} rd_state_e;
  function automatic int empty_w(int dwidth);
    return $clog2(dwidth / 8);
  endfunction
  function automatic int len_w(int max_words);
    return $clog2(max_words + 2);
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/pkt_buf_ram.sv
// pkt_buf_ram: simple dual-port RAM with an enabled, registered read port
module pkt_buf_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/packet_filter_mc.sv
// packet_filter_mc: store-and-forward Avalon-ST filter; drops by channel mask or length via write-pointer rollback
module packet_filter_mc
  import pkt_filter_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int CHAN_W     = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter int DESC_LOG2  = 4,
  parameter int MIN_WORDS  = 8,
  parameter int MAX_WORDS  = 190,
  localparam int NCHAN     = 2**CHAN_W,
  localparam int EMPTY_W   = empty_w(DWIDTH)
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic [NCHAN-1:0]   chan_en_i,
  input  logic               sink_valid_i,
  output logic               sink_ready_o,
  input  logic [DWIDTH-1:0]  sink_data_i,
  input  logic               sink_sop_i,
  input  logic               sink_eop_i,
  input  logic [EMPTY_W-1:0] sink_empty_i,
  input  logic [CHAN_W-1:0]  sink_channel_i,
  output logic               src_valid_o,
  input  logic               src_ready_i,
  output logic [DWIDTH-1:0]  src_data_o,
  output logic               src_sop_o,
  output logic               src_eop_o,
  output logic [EMPTY_W-1:0] src_empty_o,
  output logic [CHAN_W-1:0]  src_channel_o,
  output logic [31:0]        cnt_fwd_o,
  output logic [31:0]        cnt_drop_chan_o,
  output logic [31:0]        cnt_drop_len_o,
  output logic [31:0]        cnt_err_o
);
  localparam int LEN_W = len_w(MAX_WORDS);
  localparam int AW    = DEPTH_LOG2 + 1;
  localparam int DAW   = DESC_LOG2 + 1;
  localparam int RW    = DWIDTH + 1 + EMPTY_W;
  wr_state_e wr_st;
  rd_state_e rd_st;
  logic [AW-1:0] wr_ptr, rd_ptr, pkt_start, start_eff, waddr;
  logic [LEN_W-1:0] len, len_eff, rem, rem_nx;
  logic [CHAN_W-1:0] chan, ch_eff;
  logic [DAW-1:0] dwp, drp;
  desc_t dmem [2**DESC_LOG2];
  desc_t head;
  logic [CHAN_MAX_W-1:0] hc;
  logic [LEN_MAX_W-1:0] hl;
  logic [RW-1:0] rdata;
  logic data_full, desc_full, desc_empty, acc, store, eop_chk, len_ok, commit, ovr_drop, err;
  logic adv, have, pop, re;
  always_comb begin
    data_full = (wr_ptr - rd_ptr) == AW'(2**DEPTH_LOG2);
    desc_full = (dwp - drp) == DAW'(2**DESC_LOG2);
    desc_empty = dwp == drp;
    sink_ready_o = ~data_full & ~desc_full;
    acc = sink_valid_i & sink_ready_o;
    // a SOP inside a packet restarts at the old packet's start, rolling it back implicitly
    start_eff = (sink_sop_i && wr_st == W_IDLE) ? wr_ptr : pkt_start;
    waddr = sink_sop_i ? start_eff : wr_ptr;
    len_eff = sink_sop_i ? LEN_W'(1) : len + LEN_W'(1);
    ch_eff = sink_sop_i ? sink_channel_i : chan;
    store = acc & (wr_st == W_IDLE ? sink_sop_i
                 : (wr_st == W_PKT) & (sink_sop_i | (len != LEN_W'(MAX_WORDS))));
    eop_chk = store & sink_eop_i;
    len_ok = len_eff >= LEN_W'(MIN_WORDS);
    commit = eop_chk & len_ok & chan_en_i[ch_eff];
    ovr_drop = acc & sink_eop_i & ((wr_st == W_OVR) | ((wr_st == W_PKT) & ~store));
    err = acc & (wr_st == W_IDLE ? ~sink_sop_i : (wr_st == W_PKT) & sink_sop_i);
    head = dmem[drp[DESC_LOG2-1:0]];
    {hc, hl} = head;
    adv = ~src_valid_o | src_ready_i;
    have = rd_st == R_XFER;
    pop = adv & ~have & ~desc_empty;
    re = adv & (have | ~desc_empty);
    rem_nx = pop ? LEN_W'(hl) - LEN_W'(1) : rem - LEN_W'(1);
  end
  pkt_buf_ram #(.W(RW), .AW(DEPTH_LOG2)) u_ram (
    .clk   (clk_i),
    .rst   (srst_i),
    .we    (store),
    .waddr (waddr[DEPTH_LOG2-1:0]),
    .wdata ({sink_empty_i, sink_eop_i, sink_data_i}),
    .re    (re),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );
  assign src_data_o  = rdata[DWIDTH-1:0];
  assign src_eop_o   = rdata[DWIDTH];
  assign src_empty_o = rdata[RW-1 -: EMPTY_W];
  always_ff @(posedge clk_i) begin
    if (commit) dmem[dwp[DESC_LOG2-1:0]] <= '{channel: CHAN_MAX_W'(ch_eff), len: LEN_MAX_W'(len_eff)};
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_st <= W_IDLE;
      wr_ptr <= '0;
      pkt_start <= '0;
      len <= '0;
      chan <= '0;
      dwp <= '0;
      cnt_err_o <= '0;
      cnt_drop_len_o <= '0;
      cnt_drop_chan_o <= '0;
    end else begin
      if (store) begin
        pkt_start <= start_eff;
        len <= len_eff;
        chan <= ch_eff;
      end
      wr_ptr <= store ? ((eop_chk & ~commit) ? start_eff : waddr + AW'(1))
              : ovr_drop ? pkt_start : wr_ptr;
      wr_st <= store ? (sink_eop_i ? W_IDLE : W_PKT)
             : ovr_drop ? W_IDLE
             : (acc && wr_st == W_PKT) ? W_OVR : wr_st;
      if (commit) dwp <= dwp + DAW'(1);
      cnt_err_o <= sat_inc(cnt_err_o, err);
      cnt_drop_len_o <= sat_inc(cnt_drop_len_o, ovr_drop | (eop_chk & ~len_ok));
      cnt_drop_chan_o <= sat_inc(cnt_drop_chan_o, eop_chk & len_ok & ~chan_en_i[ch_eff]);
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_st <= R_IDLE;
      rd_ptr <= '0;
      drp <= '0;
      rem <= '0;
      src_valid_o <= 1'b0;
      src_sop_o <= 1'b0;
      src_channel_o <= '0;
      cnt_fwd_o <= '0;
    end else begin
      if (adv) begin
        src_valid_o <= re;
        src_sop_o <= pop;
      end
      if (pop) begin
        src_channel_o <= CHAN_W'(hc);
        drp <= drp + DAW'(1);
      end
      if (re) begin
        rem <= rem_nx;
        rd_st <= rem_nx != '0 ? R_XFER : R_IDLE;
      end
      rd_ptr <= rd_ptr + AW'(re);
      cnt_fwd_o <= sat_inc(cnt_fwd_o, src_valid_o & src_ready_i & src_eop_o);
    end
  end
endmodule

// File: tb/tb_packet_filter_mc.sv
// tb_packet_filter_mc: table-driven packet stimulus with a word scoreboard and hand-written corner sequences
module tb_packet_filter_mc;
  logic clk = 1'b0, srst = 1'b1;
  logic [3:0] chan_en = 4'b0001;
  logic sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, src_ready = 1'b1;
  logic [63:0] sink_data = '0;
  logic [2:0] sink_empty = '0;
  logic [1:0] sink_channel = '0;
  logic sink_ready, src_valid, src_sop, src_eop;
  logic [63:0] src_data;
  logic [2:0] src_empty;
  logic [1:0] src_channel;
  logic [31:0] cnt_fwd, cnt_drop_chan, cnt_drop_len, cnt_err;
  packet_filter_mc dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .chan_en_i       (chan_en),
    .sink_valid_i    (sink_valid),
    .sink_ready_o    (sink_ready),
    .sink_data_i     (sink_data),
    .sink_sop_i      (sink_sop),
    .sink_eop_i      (sink_eop),
    .sink_empty_i    (sink_empty),
    .sink_channel_i  (sink_channel),
    .src_valid_o     (src_valid),
    .src_ready_i     (src_ready),
    .src_data_o      (src_data),
    .src_sop_o       (src_sop),
    .src_eop_o       (src_eop),
    .src_empty_o     (src_empty),
    .src_channel_o   (src_channel),
    .cnt_fwd_o       (cnt_fwd),
    .cnt_drop_chan_o (cnt_drop_chan),
    .cnt_drop_len_o  (cnt_drop_len),
    .cnt_err_o       (cnt_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [1:0]  ch;
  } word_t;
  typedef enum {FWD, DCH, DLEN} cat_e;
  typedef struct {
    int         len;
    int         ch;
    logic [3:0] en;
    cat_e       cat;
  } vec_t;
  word_t exp_q[$];
  vec_t vecs[20];
  int n_chk = 0, n_pass = 0, n_out = 0, first_cyc = -1, cyc80 = -1, last_eop_cyc = 0, stalls = 0;
  int exp_fwd = 0, exp_dch = 0, exp_dlen = 0, exp_err = 0, eop0 = 0, s0 = 0;
  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  always @(negedge clk) begin
    word_t got;
    if (!srst && src_valid && src_ready) begin
      got = {src_data, src_sop, src_eop, src_empty, src_channel};
      if (n_out == 0) first_cyc = cyc;
      if (n_out == 79) cyc80 = cyc;
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %0h expected no word", got);
      end else chk("word", got, exp_q.pop_front());
    end
  end
  task automatic send_pkt(input int len, input int ch, input int id, input bit sop_on, input bit eop_on, input bit exp);
    bit acc;
    int guard;
    for (int i = 0; i < len; i++) begin
      sink_valid = 1'b1;
      sink_sop = sop_on && i == 0;
      sink_eop = eop_on && i == len - 1;
      sink_data = {32'(id), 32'(i)};
      sink_empty = sink_eop ? 3'(id) : 3'd0;
      sink_channel = 2'(ch);
      guard = 0;
      do begin
        @(negedge clk);
        acc = sink_ready;
        @(posedge clk);
        #1;
        if (!acc) begin
          stalls++;
          guard++;
          if (guard > 5000) begin
            n_chk++;
            $display("FAIL sink_timeout: stalled %0d cycles, expected acceptance", guard);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $fatal(1);
          end
        end
      end while (!acc);
      if (sink_eop) last_eop_cyc = cyc;
      if (exp) exp_q.push_back({sink_data, sink_sop, sink_eop, sink_empty, sink_channel});
    end
    sink_valid = 1'b0;
    sink_sop = 1'b0;
    sink_eop = 1'b0;
  endtask
  task automatic drain(input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      #1;
      if (rnd) src_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    src_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{8, 0, 4'b0001, FWD};
    vecs[10] = '{8, 0, 4'b0101, FWD};
    vecs[11] = '{8, 1, 4'b0101, DCH};
    vecs[12] = '{8, 2, 4'b0101, FWD};
    vecs[13] = '{8, 3, 4'b0101, DCH};
    vecs[14] = '{7, 0, 4'b1111, DLEN};
    vecs[15] = '{8, 1, 4'b1111, FWD};
    vecs[16] = '{190, 2, 4'b1111, FWD};
    vecs[17] = '{191, 3, 4'b1111, DLEN};
    vecs[18] = '{7, 2, 4'b0000, DLEN};
    vecs[19] = '{200, 1, 4'b1111, DLEN};
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    chk("rst_sink_ready", sink_ready, 1);
    chk("rst_src_ctrl", {src_valid, src_sop, src_eop, src_empty, src_channel}, 0);
    chk("rst_src_data", src_data, 0);
    chk("rst_counters", {cnt_fwd, cnt_drop_chan, cnt_drop_len, cnt_err}, 0);
    for (int i = 0; i < 20; i++) begin
      chan_en = vecs[i].en;
      s0 = stalls;
      send_pkt(vecs[i].len, vecs[i].ch, i + 1, 1'b1, 1'b1, vecs[i].cat == FWD);
      if (i == 0) eop0 = last_eop_cyc;
      if (i == 17) chk("ovr_no_stall", stalls - s0, 0);
      exp_fwd += int'(vecs[i].cat == FWD);
      exp_dch += int'(vecs[i].cat == DCH);
      exp_dlen += int'(vecs[i].cat == DLEN);
    end
    drain(1'b0);
    chk("first_word_latency", first_cyc, eop0 + 1);
    chk("no_gaps_80_words", cyc80 - first_cyc, 79);
    chk("table_stalls", stalls, 0);
    chk("cnt_fwd_table", cnt_fwd, exp_fwd);
    chk("cnt_drop_chan", cnt_drop_chan, exp_dch);
    chk("cnt_drop_len", cnt_drop_len, exp_dlen);
    chan_en = 4'b1111;
    send_pkt(3, 0, 100, 1'b1, 1'b0, 1'b0);
    send_pkt(8, 0, 101, 1'b1, 1'b1, 1'b1);
    send_pkt(1, 0, 102, 1'b0, 1'b0, 1'b0);
    send_pkt(8, 1, 103, 1'b1, 1'b1, 1'b1);
    exp_err += 2;
    exp_fwd += 2;
    drain(1'b0);
    chk("cnt_err", cnt_err, exp_err);
    chk("cnt_fwd_err_seq", cnt_fwd, exp_fwd);
    src_ready = 1'b0;
    s0 = stalls;
    send_pkt(128, 2, 110, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send_pkt(129, 3, 111, 1'b1, 1'b1, 1'b1);
    chk("fill_no_stall", stalls - s0, 0);
    chk("full_ready_low", sink_ready, 0);
    exp_fwd += 2;
    drain(1'b1);
    chk("ready_after_drain", sink_ready, 1);
    chk("cnt_fwd_full", cnt_fwd, exp_fwd);
    chk("counters_final", {cnt_drop_chan, cnt_drop_len, cnt_err}, {32'(exp_dch), 32'(exp_dlen), 32'(exp_err)});
    src_ready = 1'b0;
    send_pkt(8, 0, 120, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("held_before_rst", src_valid, 1);
    send_pkt(4, 1, 121, 1'b1, 1'b0, 1'b0);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    chk("mid_rst_src", {src_valid, src_sop, src_eop, src_empty, src_channel}, 0);
    chk("mid_rst_data", src_data, 0);
    chk("mid_rst_counters", {cnt_fwd, cnt_drop_chan, cnt_drop_len, cnt_err}, 0);
    chk("mid_rst_ready", sink_ready, 1);
    src_ready = 1'b1;
    send_pkt(8, 2, 122, 1'b1, 1'b1, 1'b1);
    drain(1'b0);
    chk("cnt_fwd_after_rst", cnt_fwd, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
